// File: rtl/freecell_pkg.sv
// Shared FreeCell definitions: selector codes, control-character ASCII values
// and the move-entry FSM state type. Used by the core, move entry and benches.
package freecell_pkg;

  // Selector codes understood by the core
  localparam logic [3:0] COL1   = 4'd0;
  localparam logic [3:0] COL2   = 4'd1;
  localparam logic [3:0] COL3   = 4'd2;
  localparam logic [3:0] COL4   = 4'd3;
  localparam logic [3:0] COL5   = 4'd4;
  localparam logic [3:0] COL6   = 4'd5;
  localparam logic [3:0] COL7   = 4'd6;
  localparam logic [3:0] COL8   = 4'd7;
  localparam logic [3:0] CELL_A = 4'd8;
  localparam logic [3:0] CELL_B = 4'd9;
  localparam logic [3:0] CELL_C = 4'd10;
  localparam logic [3:0] CELL_D = 4'd11;
  localparam logic [3:0] HOME   = 4'd12;
  // home->home is always rejected by the core, so it is a safe idle code
  localparam logic [3:0] NOOP   = HOME;

  // Control characters
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Move-entry sequencer states
  typedef enum logic [1:0] {
    WAIT_SRC = 2'd0,
    WAIT_DST = 2'd1,
    ISSUE    = 2'd2,
    DONE     = 2'd3
  } fc_state_e;

endpackage

// File: rtl/freecell_char_decode.sv
// Combinational ASCII classifier: selector characters map to core selector
// codes; whitespace and ESC are flagged separately. Anything else is "bad".
module freecell_char_decode
  import freecell_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_sel,
  output logic       is_ignore,
  output logic       is_esc,
  output logic [3:0] code
);

  // Classify the character and produce its selector code (NOOP when not a selector)
  always_comb begin
    is_sel    = 1'b0;
    is_ignore = 1'b0;
    is_esc    = 1'b0;
    code      = NOOP;
    if (char_in >= 8'h31 && char_in <= 8'h38) begin          // '1'..'8'
      is_sel = 1'b1;
      code   = COL1 + 4'(char_in - 8'h31);
    end else if (char_in >= 8'h61 && char_in <= 8'h64) begin // 'a'..'d'
      is_sel = 1'b1;
      code   = CELL_A + 4'(char_in - 8'h61);
    end else if (char_in >= 8'h41 && char_in <= 8'h44) begin // 'A'..'D'
      is_sel = 1'b1;
      code   = CELL_A + 4'(char_in - 8'h41);
    end else if (char_in == 8'h68 || char_in == 8'h48) begin // 'h' / 'H'
      is_sel = 1'b1;
      code   = HOME;
    end else if (char_in == ASCII_SPACE || char_in == ASCII_CR || char_in == ASCII_LF) begin
      is_ignore = 1'b1;
    end else if (char_in == ASCII_ESC) begin
      is_esc = 1'b1;
    end
  end

endmodule

// File: rtl/freecell_move_entry.sv
// Move sequencer in front of the FreeCell core: assembles two-character moves,
// holds each encoded move for HOLD_CYCLES cycles, and otherwise drives the
// home->home no-op so the core never sees stale selectors.
module freecell_move_entry
  import freecell_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             win,
  output logic [3:0]       source,
  output logic [3:0]       dest,
  output logic             move_valid,
  output logic             bad_char,
  output logic [CNT_W-1:0] move_count
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  fc_state_e     state_reg;
  logic [3:0]    src_reg;
  logic [HW-1:0] hold_reg;
  logic          win_pending_reg;

  logic          is_sel;
  logic          is_ignore;
  logic          is_esc;
  logic [3:0]    code;
  logic          xfer;
  logic          win_seen;
  logic          issue_start;

  freecell_char_decode u_decode (
    .char_in   (char_in),
    .is_sel    (is_sel),
    .is_ignore (is_ignore),
    .is_esc    (is_esc),
    .code      (code)
  );

  // Characters are only taken while assembling a move
  assign char_ready  = (state_reg == WAIT_SRC) || (state_reg == WAIT_DST);
  assign xfer        = char_valid && char_ready;
  // A win seen during ISSUE is remembered until the move has been presented
  assign win_seen    = win || win_pending_reg;
  assign issue_start = xfer && is_sel && (state_reg == WAIT_DST);

  // Sequencer FSM with registered selector outputs and issued-move counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= WAIT_SRC;
      src_reg         <= NOOP;
      hold_reg        <= '0;
      win_pending_reg <= 1'b0;
      source          <= NOOP;
      dest            <= NOOP;
      move_valid      <= 1'b0;
      bad_char        <= 1'b0;
      move_count      <= '0;
    end else begin
      bad_char <= 1'b0;
      if (win) begin
        win_pending_reg <= 1'b1;
      end
      case (state_reg)
        WAIT_SRC, WAIT_DST: begin
          if (xfer) begin
            if (is_sel) begin
              if (state_reg == WAIT_SRC) begin
                src_reg   <= code;
                state_reg <= WAIT_DST;
              end else begin
                source     <= src_reg;
                dest       <= code;
                move_valid <= 1'b1;
                hold_reg   <= HW'(HOLD_CYCLES);
                state_reg  <= ISSUE;
              end
            end else if (is_esc) begin
              state_reg <= WAIT_SRC;
            end else if (!is_ignore) begin
              // unrecognised: drop any pending source and flag it
              bad_char  <= 1'b1;
              state_reg <= WAIT_SRC;
            end
          end
          // a completed move still gets issued; otherwise stop right away
          if (win_seen && !issue_start) begin
            state_reg <= DONE;
          end
        end
        ISSUE: begin
          if (hold_reg == HW'(1)) begin
            source     <= NOOP;
            dest       <= NOOP;
            move_valid <= 1'b0;
            if (move_count != {CNT_W{1'b1}}) begin
              move_count <= move_count + CNT_W'(1);
            end
            state_reg <= win_seen ? DONE : WAIT_SRC;
          end else begin
            hold_reg <= hold_reg - HW'(1);
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= WAIT_SRC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freecell_move_entry.sv
// Bench for freecell_move_entry: two instances (hold 1 / 16-bit count and
// hold 3 / 2-bit count) driven by directed and random character streams.
// Expected moves are pushed to a per-instance queue; a negedge monitor pops
// and compares whenever a move is presented.
module tb_freecell_move_entry;

  typedef struct {
    int s;
    int d;
  } mv_t;

  logic       clock;
  logic       reset      [2];
  logic [7:0] char_in    [2];
  logic       char_valid [2];
  logic       char_ready [2];
  logic       win        [2];
  logic [3:0] source     [2];
  logic [3:0] dest       [2];
  logic       move_valid [2];
  logic       bad_char   [2];
  logic [15:0] mc0;
  logic [1:0]  mc1;

  int checks = 0;
  int failures = 0;

  mv_t q0[$];
  mv_t q1[$];
  int  pend     [2];
  int  moves    [2];
  int  run      [2];
  bit  in_reset [2];
  bit  mon_en = 0;

  freecell_move_entry #(.HOLD_CYCLES(1), .CNT_W(16)) u_dut0 (
    .clock(clock), .reset(reset[0]), .char_in(char_in[0]), .char_valid(char_valid[0]),
    .char_ready(char_ready[0]), .win(win[0]), .source(source[0]), .dest(dest[0]),
    .move_valid(move_valid[0]), .bad_char(bad_char[0]), .move_count(mc0)
  );

  freecell_move_entry #(.HOLD_CYCLES(3), .CNT_W(2)) u_dut1 (
    .clock(clock), .reset(reset[1]), .char_in(char_in[1]), .char_valid(char_valid[1]),
    .char_ready(char_ready[1]), .win(win[1]), .source(source[1]), .dest(dest[1]),
    .move_valid(move_valid[1]), .bad_char(bad_char[1]), .move_count(mc1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int cnt_max(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic int count_of(input int i);
    return (i == 0) ? int'(mc0) : int'(mc1);
  endfunction

  // Reference encoding by table lookup: -1 when not a selector
  function automatic int enc(input logic [7:0] c);
    string cols = "12345678";
    string lc   = "abcd";
    string uc   = "ABCD";
    for (int k = 0; k < 8; k++) if (c == cols[k]) return k;
    for (int k = 0; k < 4; k++) if (c == lc[k] || c == uc[k]) return 8 + k;
    if (c == "h" || c == "H") return 12;
    return -1;
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model of one accepted character; returns 1 when a bad_char pulse is due
  function automatic bit model_accept(input int i, input logic [7:0] c);
    int  e;
    mv_t m;
    e = enc(c);
    if (e >= 0) begin
      if (pend[i] < 0) begin
        pend[i] = e;
      end else begin
        m.s = pend[i];
        m.d = e;
        if (i == 0) q0.push_back(m); else q1.push_back(m);
        moves[i]++;
        pend[i] = -1;
      end
      return 1'b0;
    end
    if (c == 8'h20 || c == 8'h0A || c == 8'h0D) return 1'b0;
    pend[i] = -1;
    return (c != 8'h1B);
  endfunction

  // Called at a negedge; returns at the negedge following the transfer
  task automatic send(input int i, input logic [7:0] c, output int waits);
    bit expb;
    char_in[i]    = c;
    char_valid[i] = 1'b1;
    waits = 0;
    while (!char_ready[i] && waits < 50) begin
      @(negedge clock);
      waits++;
    end
    if (!char_ready[i]) begin
      chk(1'b0, "ready_timeout", 0, 1);
      char_valid[i] = 1'b0;
    end else begin
      @(posedge clock);
      expb = model_accept(i, c);
      @(negedge clock);
      char_valid[i] = 1'b0;
      chk(bad_char[i] == expb, "bad_char", int'(bad_char[i]), int'(expb));
    end
  endtask

  task automatic send_str(input int i, input string s);
    int w;
    for (int k = 0; k < s.len(); k++) send(i, s[k], w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor step: pop and compare on move start, check hold length and count on fall
  task automatic mon_step(input int i);
    mv_t m;
    int  exp_cnt;
    if (reset[i] || in_reset[i]) begin
      run[i] = 0;
      return;
    end
    if (move_valid[i]) begin
      chk(!char_ready[i], "ready_in_issue", int'(char_ready[i]), 0);
      if (run[i] == 0) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk(1'b0, "unexpected_move", int'(source[i]) * 16 + int'(dest[i]), -1);
        end else begin
          m = (i == 0) ? q0.pop_front() : q1.pop_front();
          $display("move dut%0d src=%0d dst=%0d exp=%0d/%0d", i, source[i], dest[i], m.s, m.d);
          chk(int'(source[i]) == m.s, "move_source", int'(source[i]), m.s);
          chk(int'(dest[i]) == m.d, "move_dest", int'(dest[i]), m.d);
        end
      end
      run[i]++;
    end else begin
      chk(source[i] == 4'd12 && dest[i] == 4'd12, "idle_noop",
          int'(source[i]) * 16 + int'(dest[i]), 12 * 16 + 12);
      if (run[i] > 0) begin
        chk(run[i] == hold_of(i), "hold_len", run[i], hold_of(i));
        exp_cnt = (moves[i] > cnt_max(i)) ? cnt_max(i) : moves[i];
        chk(count_of(i) == exp_cnt, "move_count", count_of(i), exp_cnt);
        run[i] = 0;
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon_step(0);
      mon_step(1);
    end
  end

  // Expect the terminal state: no-op, no move, not ready, count frozen
  task automatic check_done(input int i, input int n);
    int exp_cnt;
    exp_cnt = (moves[i] > cnt_max(i)) ? cnt_max(i) : moves[i];
    char_in[i]    = "1";
    char_valid[i] = 1'b1;
    repeat (n) begin
      @(negedge clock);
      chk(!char_ready[i], "done_ready", int'(char_ready[i]), 0);
      chk(!move_valid[i], "done_valid", int'(move_valid[i]), 0);
      chk(count_of(i) == exp_cnt, "done_count", count_of(i), exp_cnt);
    end
    char_valid[i] = 1'b0;
  endtask

  initial begin
    int w;
    string pool;
    logic [7:0] c;
    pool = "12345678abcdhHAD \n\rxz9@";
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; char_in[i] = 8'h00; char_valid[i] = 1'b0; win[i] = 1'b0;
      pend[i] = -1; moves[i] = 0; run[i] = 0; in_reset[i] = 1'b0;
    end
    idle(3);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk(source[i] == 4'd12 && dest[i] == 4'd12, "reset_noop",
          int'(source[i]) * 16 + int'(dest[i]), 12 * 16 + 12);
      chk(!move_valid[i], "reset_valid", int'(move_valid[i]), 0);
      chk(!bad_char[i], "reset_bad", int'(bad_char[i]), 0);
      chk(count_of(i) == 0, "reset_count", count_of(i), 0);
      chk(char_ready[i], "reset_ready", int'(char_ready[i]), 1);
    end
    mon_en = 1'b1;

    // Directed sequences on the hold-1 instance
    send_str(0, "1h");
    idle(2);
    send_str(0, "a7 \r\n85");
    send_str(0, "4x2c");
    send(0, "3", w);
    send(0, 8'h1B, w);
    send_str(0, "c2h4");
    send_str(0, "56");
    send(0, "7", w);
    chk(w == 1, "throughput_wait", w, 1);
    send(0, 8'h1B, w);

    // Random stream on the hold-1 instance
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) c = 8'h1B;
      else c = pool[$urandom_range(0, pool.len() - 1)];
      send(0, c, w);
    end
    send(0, 8'h1B, w);

    // Hold-3 instance: char_valid held while the move is presented
    send_str(1, "d h");
    send(1, "5", w);
    chk(w == 3, "ready_low_hold", w, 3);
    send(1, "6", w);
    send_str(1, "1223");
    idle(5);

    // Reset while a move is being presented
    send_str(1, "78");
    in_reset[1] = 1'b1;
    reset[1] = 1'b1;
    @(negedge clock);
    chk(!move_valid[1], "rst_mid_valid", int'(move_valid[1]), 0);
    chk(source[1] == 4'd12 && dest[1] == 4'd12, "rst_mid_noop",
        int'(source[1]) * 16 + int'(dest[1]), 12 * 16 + 12);
    chk(count_of(1) == 0, "rst_mid_count", count_of(1), 0);
    reset[1] = 1'b0;
    moves[1] = 0;
    pend[1] = -1;
    q1.delete();
    @(negedge clock);
    in_reset[1] = 1'b0;
    send_str(1, "1h");
    idle(5);

    // Win during ISSUE: move completes, then terminal state until reset
    send_str(1, "23");
    win[1] = 1'b1;
    @(negedge clock);
    win[1] = 1'b0;
    idle(4);
    check_done(1, 6);

    send_str(0, "35");
    win[0] = 1'b1;
    @(negedge clock);
    win[0] = 1'b0;
    idle(2);
    check_done(0, 6);

    chk(q0.size() == 0, "queue0_drained", q0.size(), 0);
    chk(q1.size() == 0, "queue1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freecell_move_entry.md
# freecell_move_entry

Front-end move sequencer that feeds the FreeCell core. It accepts a byte stream of ASCII move characters (keyboard/UART side) and assembles each two-character move ("1h", "a7", "85", …). It encodes each move into the core's 4-bit source/destination selector codes and presents it for a fixed number of cycles. Between moves it drives a guaranteed-illegal no-op code so the core never acts on stale selectors; legality of a well-formed move is judged by the core, not here.

## Interface
- HOLD_CYCLES, 1, cycles a decoded move is held on source/dest (≥1)
- CNT_W, 16, width of issued-move counter

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- char_in  in  8  ASCII character
- char_valid  in  1  char_in valid this cycle
- char_ready  out  1  block accepts char_in this cycle
- win  in  1  win flag from the core
- source  out  4  source selector to core
- dest  out  4  destination selector to core
- move_valid  out  1  high while source/dest carry a real move
- bad_char  out  1  one-cycle pulse: unrecognised character discarded
- move_count  out  CNT_W  moves issued since reset, saturating

## Operation
- Encoding: '1'–'8' → 0–7 (tableau columns); 'a'–'d' / 'A'–'D' → 8–11 (free cells); 'h' / 'H' → 12 (home).
- No-op code: source = dest = 12 (home→home, always illegal for the core).
- Ignored characters: space 0x20, LF 0x0A, CR 0x0D. They are accepted and cause no state change and no pulse.
- Escape 0x1B: discards a pending source character; returns to WAIT_SRC; no pulse.
- Any other character: discarded; bad_char pulses. If the FSM is in WAIT_DST, the pending source is dropped and the FSM returns to WAIT_SRC.
- Home as source ("h4") and identical source/dest ("11") are forwarded unchanged. The core rejects illegal moves.
- FSM states:
  - WAIT_SRC: a valid selector char is latched as src_q → WAIT_DST.
  - WAIT_DST: a valid selector char is latched as dst_q; hold counter loaded with HOLD_CYCLES → ISSUE.
  - ISSUE: source = src_q, dest = dst_q, move_valid = 1; counter decrements each cycle. When it reaches 0 → WAIT_SRC and move_count increments (saturates at all-ones).
  - DONE: entered from any state on the first cycle after win = 1 is sampled. If in ISSUE, DONE is entered only after ISSUE completes. DONE exits only on reset.
- char_ready = 1 in WAIT_SRC and WAIT_DST; 0 in ISSUE and DONE.
- A character transfers only when char_valid && char_ready at a rising edge.

## Timing
- Reset values:
  - state WAIT_SRC
  - source = dest = 12, move_valid = 0
  - bad_char = 0, move_count = 0, char_ready = 1 in the cycle after reset deasserts
- source, dest, move_valid, bad_char and move_count are registered. char_ready is decoded from state.
- Latency: destination char accepted at edge N → move_valid = 1 with the encoded codes from edge N to edge N+HOLD_CYCLES. No-op code from the following edge.
- move_count updates on the same edge where move_valid falls.
- Earliest next character is accepted at the first edge after move_valid falls. Maximum throughput is one move per 2 + HOLD_CYCLES cycles.
- bad_char is high for exactly the cycle after the offending edge.
- Reset asserted mid-ISSUE or mid-move: all outputs take reset values at that edge and the pending move is lost.
- win and a character transfer on the same edge: the character is processed normally; DONE follows.

## Structure
- Package freecell_pkg holds:
  - selector constants COL1..COL8 = 0..7, CELL_A..CELL_D = 8..11, HOME = 12, NOOP = HOME
  - ASCII constants for ESC, space, CR, LF
  - the FSM state enum
- Package is shared with the core and the benches.
- Sub-module freecell_char_decode (combinational): char → {is_sel, is_ignore, is_esc, code[3:0]}. Reused by the display/echo path.

## Test plan
- Reset, then "1h" with HOLD_CYCLES = 1 → one cycle of source = 0, dest = 12, move_valid = 1; then no-op 12/12; move_count = 1.
- "a7" then " \r\n" then "85" → moves (8,6) and (7,4) in order; whitespace creates no moves and no bad_char; move_count = 2.
- "4x" → bad_char pulse after 'x'; no move issued. A following "2c" → (1,10).
- '3' then ESC then "c2" → only (10,1) issued. "h4" → (12,3) forwarded.
- HOLD_CYCLES = 3, "d h" with char_valid held high during ISSUE → codes (11,12) for exactly 3 cycles; char_ready = 0 throughout; the next char is taken only after.
- win pulsed during ISSUE → the move completes; char_ready stays 0; outputs hold no-op until reset. Reset mid-ISSUE → no-op and move_count = 0 at the next edge.
